// File: rtl/on_chip_mem_pkg.sv
// Shared types and constants for the s2 read sequencer of the on-chip sample memory.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package on_chip_mem_pkg;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 64;
  localparam int DEPTH  = 8960;

  // Highest valid word address; the memory is not a power of two deep.
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    DRAIN,
    FLUSH,
    DONE
  } seq_state_t;

  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } fifo_ent_t;

  // Sequential word address with wrap at DEPTH-1 rather than 2^ADDR_W-1.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    return (a == LAST_ADDR) ? '0 : a + ADDR_W'(1);
  endfunction

endpackage

// File: rtl/on_chip_mem_rd_sequencer_if.sv
// Valid/ready stream carrying memory words from the sequencer to the consumer.
// Latency: n/a (wires only).
// Backpressure: consumer holds out_ready low to stall; data/last hold while out_valid=1.
interface on_chip_mem_rd_sequencer_if;
  import on_chip_mem_pkg::*;

  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_last;
  logic              out_ready;

  modport master (output out_data, output out_valid, output out_last, input out_ready);
  modport slave  (input out_data, input out_valid, input out_last, output out_ready);

endinterface

// File: rtl/mem_rd_skid_fifo.sv
// Two-entry FIFO of {last, data} absorbing RAM read latency and downstream stalls.
// Latency: a push is visible at the head the next cycle; head outputs are registers.
// Backpressure: caller must never push into a full FIFO; clear empties it in one cycle.
//
// Ports: clk/reset; push_i + push_ent_i write; pop_i removes the head; clear_i flushes;
//        count_o is the occupancy; head_o/head_vld_o present the oldest entry.
module mem_rd_skid_fifo
  import on_chip_mem_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      push_i,
  input  fifo_ent_t push_ent_i,
  input  logic      pop_i,
  input  logic      clear_i,
  output logic [1:0] count_o,
  output fifo_ent_t head_o,
  output logic      head_vld_o
);

  fifo_ent_t  ent0_q;  // head
  fifo_ent_t  ent1_q;
  logic [1:0] count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= 2'd0;
      ent0_q  <= '0;
      ent1_q  <= '0;
    end else if (clear_i) begin
      count_q <= 2'd0;
    end else begin
      case ({push_i, pop_i})
        2'b10: begin
          if (count_q == 2'd0) ent0_q <= push_ent_i;
          else                 ent1_q <= push_ent_i;
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          // Only shift when a second entry exists, so the head register
          // does not pick up a stale slot when the FIFO drains.
          if (count_q == 2'd2) ent0_q <= ent1_q;
          count_q <= count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd2) begin
            ent0_q <= ent1_q;
            ent1_q <= push_ent_i;
          end else begin
            ent0_q <= push_ent_i;
          end
        end
        default: ;
      endcase
    end
  end

  assign count_o    = count_q;
  assign head_o     = ent0_q;
  assign head_vld_o = (count_q != 2'd0);

endmodule

// File: rtl/on_chip_mem_rd_sequencer.sv
// Streams a window of s2 memory words to a consumer, optionally looping, until done or abort.
// Latency: cfg_start -> first issue 1 cycle, first out_valid 3 cycles; 1 word/cycle sustained.
// Backpressure: issue throttled so FIFO + in-flight read never exceeds 2 entries.
//
// Ports: clk/reset; cfg_* start/abort a run; busy_o/done_o report run status;
//        mem_* drive the s2 port (1-cycle read latency); out_if is the output stream.
module on_chip_mem_rd_sequencer
  import on_chip_mem_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_start_i,
  input  logic [ADDR_W-1:0] cfg_base_i,
  input  logic [ADDR_W-1:0] cfg_length_i,
  input  logic              cfg_loop_i,
  input  logic              cfg_abort_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] mem_address_o,
  output logic              mem_chipselect_o,
  output logic              mem_clken_o,
  output logic              mem_write_o,
  output logic [7:0]        mem_byteenable_o,
  input  logic [DATA_W-1:0] mem_readdata_i,
  on_chip_mem_rd_sequencer_if.master out_if
);

  seq_state_t        state_q;
  logic              busy_q;
  logic              done_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] rem_q;      // words still to issue in the current pass
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] len_q;
  logic              loop_q;
  logic              inflight_q;
  logic              inflight_last_q;

  fifo_ent_t  head;
  fifo_ent_t  push_ent;
  logic       head_vld;
  logic [1:0] fifo_count;
  logic       pop;
  logic       push;
  logic       clear;
  logic       issue;
  logic       pass_end;
  logic [2:0] level;

  assign pop = head_vld & out_if.out_ready;

  // Occupancy the FIFO will have next cycle if nothing new is issued now.
  assign level = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};

  assign pass_end = (rem_q == ADDR_W'(1));
  assign issue    = (state_q == RUN) && (rem_q != '0) && (level < 3'd2);

  // A word landing during FLUSH belongs to the aborted run and is dropped.
  assign push     = inflight_q && (state_q != FLUSH);
  assign clear    = cfg_abort_i && ((state_q == RUN) || (state_q == DRAIN));
  assign push_ent = '{last: inflight_last_q, data: mem_readdata_i};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      addr_q          <= '0;
      rem_q           <= '0;
      base_q          <= '0;
      len_q           <= '0;
      loop_q          <= 1'b0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      inflight_q      <= issue;
      inflight_last_q <= issue && pass_end;
      done_q          <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cfg_start_i) begin
            base_q <= cfg_base_i;
            len_q  <= cfg_length_i;
            loop_q <= cfg_loop_i;
            addr_q <= cfg_base_i;
            rem_q  <= cfg_length_i;
            busy_q <= 1'b1;
            if (cfg_length_i == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          if (cfg_abort_i) begin
            state_q <= FLUSH;
          end else if (issue) begin
            if (pass_end) begin
              if (loop_q) begin
                addr_q <= base_q;
                rem_q  <= len_q;
              end else begin
                state_q <= DRAIN;
              end
            end else begin
              addr_q <= next_addr(addr_q);
              rem_q  <= rem_q - ADDR_W'(1);
            end
          end
        end
        DRAIN: begin
          if (cfg_abort_i) begin
            state_q <= FLUSH;
          end else if (level == 3'd0) begin
            // Last beat is being accepted now, so done lines up with the next cycle.
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        FLUSH: begin
          state_q <= DONE;
          done_q  <= 1'b1;
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  mem_rd_skid_fifo u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_i     (push),
    .push_ent_i (push_ent),
    .pop_i      (pop),
    .clear_i    (clear),
    .count_o    (fifo_count),
    .head_o     (head),
    .head_vld_o (head_vld)
  );

  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign mem_address_o    = addr_q;
  assign mem_chipselect_o = issue;
  assign mem_clken_o      = issue;
  assign mem_write_o      = 1'b0;
  assign mem_byteenable_o = 8'hFF;

  assign out_if.out_data  = head.data;
  assign out_if.out_last  = head.last;
  assign out_if.out_valid = head_vld;

endmodule

// File: tb/tb_on_chip_mem_rd_sequencer.sv
// Directed bench for the s2 read sequencer: cycle table for a basic run plus
// hand sequences for wrap, backpressure, loop/abort, empty run and reset.
module tb_on_chip_mem_rd_sequencer;
  import on_chip_mem_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              cfg_start;
  logic [ADDR_W-1:0] cfg_base;
  logic [ADDR_W-1:0] cfg_length;
  logic              cfg_loop;
  logic              cfg_abort;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_cs;
  logic              mem_clken;
  logic              mem_write;
  logic [7:0]        mem_be;
  logic [DATA_W-1:0] mem_rdata = '0;

  on_chip_mem_rd_sequencer_if sif();

  always #5 clk = ~clk;

  on_chip_mem_rd_sequencer dut (
    .clk              (clk),
    .reset            (reset),
    .cfg_start_i      (cfg_start),
    .cfg_base_i       (cfg_base),
    .cfg_length_i     (cfg_length),
    .cfg_loop_i       (cfg_loop),
    .cfg_abort_i      (cfg_abort),
    .busy_o           (busy),
    .done_o           (done),
    .mem_address_o    (mem_address),
    .mem_chipselect_o (mem_cs),
    .mem_clken_o      (mem_clken),
    .mem_write_o      (mem_write),
    .mem_byteenable_o (mem_be),
    .mem_readdata_i   (mem_rdata),
    .out_if           (sif.master)
  );

  int checks = 0;
  int errors = 0;

  function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    return {16'hBEEF, 2'b00, a, 16'h1234, 2'b00, a};
  endfunction

  // Memory model: one-cycle registered read.
  always @(posedge clk) begin
    if (mem_cs && mem_clken && !mem_write) mem_rdata <= mem_word(mem_address);
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: issued addresses, accepted beats, done pulses, stall stability.
  logic [ADDR_W-1:0] addr_log[$];
  logic [DATA_W:0]   beat_log[$];
  int                done_cnt = 0;
  logic              prev_stall = 1'b0;
  logic [DATA_W:0]   prev_beat = '0;

  always @(negedge clk) begin
    if (mem_cs) addr_log.push_back(mem_address);
    if (sif.out_valid && sif.out_ready) beat_log.push_back({sif.out_last, sif.out_data});
    if (done) done_cnt++;
    if (prev_stall) chk("stall_hold", {sif.out_valid, sif.out_last, sif.out_data}, {1'b1, prev_beat});
    prev_stall = !reset && sif.out_valid && !sif.out_ready;
    prev_beat  = {sif.out_last, sif.out_data};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    addr_log.delete();
    beat_log.delete();
    done_cnt = 0;
  endtask

  // Pulses cfg_start in the current cycle; returns in the following cycle.
  task automatic start_run(input int base, input int len, input logic loop);
    cfg_base   = ADDR_W'(base);
    cfg_length = ADDR_W'(len);
    cfg_loop   = loop;
    cfg_start  = 1'b1;
    tick();
    cfg_start  = 1'b0;
  endtask

  task automatic wait_end(input string name, input int max_cyc);
    int n;
    n = 0;
    while (!(done_cnt > 0 && busy === 1'b0) && n < max_cyc) begin
      tick();
      n++;
    end
    if (n >= max_cyc) begin
      errors++;
      $display("FAIL %s: run did not end within %0d cycles", name, max_cyc);
    end
  endtask

  typedef struct {
    logic              start;
    logic              cs;
    logic [ADDR_W-1:0] addr;
    logic              vld;
    logic              last;
    logic [DATA_W-1:0] data;
    logic              done;
    logic              busy;
  } vec_t;

  vec_t vec[9];

  initial begin
    // Basic run base=0 len=4 loop=0 ready=1, one row per cycle from the start pulse.
    vec[0] = '{start:1'b1, cs:1'b0, addr:14'd0, vld:1'b0, last:1'b0, data:'0,          done:1'b0, busy:1'b0};
    vec[1] = '{start:1'b0, cs:1'b1, addr:14'd0, vld:1'b0, last:1'b0, data:'0,          done:1'b0, busy:1'b1};
    vec[2] = '{start:1'b0, cs:1'b1, addr:14'd1, vld:1'b0, last:1'b0, data:'0,          done:1'b0, busy:1'b1};
    vec[3] = '{start:1'b0, cs:1'b1, addr:14'd2, vld:1'b1, last:1'b0, data:mem_word(0), done:1'b0, busy:1'b1};
    vec[4] = '{start:1'b0, cs:1'b1, addr:14'd3, vld:1'b1, last:1'b0, data:mem_word(1), done:1'b0, busy:1'b1};
    vec[5] = '{start:1'b0, cs:1'b0, addr:14'd0, vld:1'b1, last:1'b0, data:mem_word(2), done:1'b0, busy:1'b1};
    vec[6] = '{start:1'b0, cs:1'b0, addr:14'd0, vld:1'b1, last:1'b1, data:mem_word(3), done:1'b0, busy:1'b1};
    vec[7] = '{start:1'b0, cs:1'b0, addr:14'd0, vld:1'b0, last:1'b0, data:'0,          done:1'b1, busy:1'b1};
    vec[8] = '{start:1'b0, cs:1'b0, addr:14'd0, vld:1'b0, last:1'b0, data:'0,          done:1'b0, busy:1'b0};

    reset         = 1'b1;
    cfg_start     = 1'b0;
    cfg_base      = '0;
    cfg_length    = '0;
    cfg_loop      = 1'b0;
    cfg_abort     = 1'b0;
    sif.out_ready = 1'b0;
    repeat (3) tick();
    reset = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_busy",  busy, 0);
    chk("rst_done",  done, 0);
    chk("rst_valid", sif.out_valid, 0);
    chk("rst_last",  sif.out_last, 0);
    chk("rst_data",  sif.out_data, 0);
    chk("rst_cs",    mem_cs, 0);
    chk("rst_clken", mem_clken, 0);
    chk("rst_addr",  mem_address, 0);
    chk("rst_write", mem_write, 0);
    chk("rst_be",    mem_be, 8'hFF);

    // Basic run from the table
    sif.out_ready = 1'b1;
    cfg_base   = '0;
    cfg_length = 14'd4;
    cfg_loop   = 1'b0;
    tick();
    for (int k = 0; k < 9; k++) begin
      cfg_start = vec[k].start;
      @(negedge clk);
      chk($sformatf("basic_cs[%0d]", k),   mem_cs, vec[k].cs);
      chk($sformatf("basic_busy[%0d]", k), busy, vec[k].busy);
      chk($sformatf("basic_done[%0d]", k), done, vec[k].done);
      chk($sformatf("basic_vld[%0d]", k),  sif.out_valid, vec[k].vld);
      if (vec[k].cs) chk($sformatf("basic_addr[%0d]", k), mem_address, vec[k].addr);
      if (vec[k].vld) begin
        chk($sformatf("basic_last[%0d]", k), sif.out_last, vec[k].last);
        chk($sformatf("basic_data[%0d]", k), sif.out_data, vec[k].data);
      end
      tick();
    end
    cfg_start = 1'b0;

    // Address wrap at DEPTH-1
    clear_logs();
    start_run(8958, 4, 1'b0);
    wait_end("wrap_end", 40);
    chk("wrap_naddr", addr_log.size(), 4);
    chk("wrap_nbeat", beat_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < addr_log.size()) chk($sformatf("wrap_addr[%0d]", i), addr_log[i], (8958 + i) % DEPTH);
      if (i < beat_log.size())
        chk($sformatf("wrap_beat[%0d]", i), beat_log[i],
            {i == 3, mem_word(ADDR_W'((8958 + i) % DEPTH))});
    end
    chk("wrap_done_cnt", done_cnt, 1);

    // Backpressure: ready pattern 1,0,0,1 repeating
    clear_logs();
    start_run(200, 8, 1'b0);
    begin
      int n;
      n = 0;
      while (!(done_cnt > 0 && busy === 1'b0) && n < 100) begin
        sif.out_ready = (n % 4 == 0) || (n % 4 == 3);
        tick();
        n++;
      end
      if (n >= 100) begin
        errors++;
        $display("FAIL bp_end: run did not end within 100 cycles");
      end
    end
    sif.out_ready = 1'b1;
    chk("bp_nbeat", beat_log.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < beat_log.size())
        chk($sformatf("bp_beat[%0d]", i), beat_log[i], {i == 7, mem_word(ADDR_W'(200 + i))});
    end
    chk("bp_done_cnt", done_cnt, 1);

    // Loop then abort in cycle 12 after start
    clear_logs();
    start_run(100, 3, 1'b1);
    repeat (11) tick();
    cfg_abort = 1'b1;
    tick();
    cfg_abort = 1'b0;
    @(negedge clk);
    chk("abort_vld_next", sif.out_valid, 0);
    chk("abort_done_next", done, 0);
    tick();
    @(negedge clk);
    chk("abort_done_2", done, 1);
    repeat (6) tick();
    chk("abort_busy_after", busy, 0);
    chk("abort_nbeat", beat_log.size(), 10);
    for (int j = 0; j < 10; j++) begin
      if (j < beat_log.size())
        chk($sformatf("loop_beat[%0d]", j), beat_log[j], {j % 3 == 2, mem_word(ADDR_W'(100 + j % 3))});
    end
    for (int j = 0; j < 6; j++) begin
      if (j < addr_log.size()) chk($sformatf("loop_addr[%0d]", j), addr_log[j], 100 + j % 3);
    end
    chk("abort_done_cnt", done_cnt, 1);

    // Empty run, with a second start while busy
    clear_logs();
    start_run(50, 0, 1'b0);
    cfg_base   = 14'd60;
    cfg_length = 14'd5;
    cfg_start  = 1'b1;
    @(negedge clk);
    chk("empty_done", done, 1);
    chk("empty_busy", busy, 1);
    tick();
    cfg_start = 1'b0;
    @(negedge clk);
    chk("empty_done_off", done, 0);
    chk("empty_busy_off", busy, 0);
    repeat (8) tick();
    chk("empty_naddr", addr_log.size(), 0);
    chk("empty_nbeat", beat_log.size(), 0);
    chk("empty_done_cnt", done_cnt, 1);

    // Reset after two beats of a length-6 run
    clear_logs();
    start_run(300, 6, 1'b0);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("mrst_busy",  busy, 0);
    chk("mrst_done",  done, 0);
    chk("mrst_valid", sif.out_valid, 0);
    chk("mrst_last",  sif.out_last, 0);
    chk("mrst_data",  sif.out_data, 0);
    chk("mrst_cs",    mem_cs, 0);
    chk("mrst_addr",  mem_address, 0);
    repeat (10) tick();
    chk("mrst_nbeat", beat_log.size(), 2);
    chk("mrst_done_cnt", done_cnt, 0);
    for (int i = 0; i < 2; i++) begin
      if (i < beat_log.size())
        chk($sformatf("mrst_beat[%0d]", i), beat_log[i], {1'b0, mem_word(ADDR_W'(300 + i))});
    end

    // Fresh run after reset
    clear_logs();
    start_run(10, 2, 1'b0);
    wait_end("fresh_end", 30);
    chk("fresh_nbeat", beat_log.size(), 2);
    for (int i = 0; i < 2; i++) begin
      if (i < beat_log.size())
        chk($sformatf("fresh_beat[%0d]", i), beat_log[i], {i == 1, mem_word(ADDR_W'(10 + i))});
    end
    chk("fresh_done_cnt", done_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/on_chip_mem_rd_sequencer.md
# on_chip_mem_rd_sequencer

Read sequencer for the 64-bit port (s2) of the dual-port on-chip sample memory. It streams a configured window of table words to a downstream noise/sample consumer over valid/ready, with optional looping. It absorbs the RAM's one-cycle read latency and downstream backpressure with a 2-entry buffer, and sustains one word per cycle when the consumer is always ready. The 32-bit port (s1) stays with the Nios master and is outside this block's control.

## Interface
- ADDR_W, 14, word address width of s2
- DATA_W, 64, s2 data width
- DEPTH, 8960, number of 64-bit words in the memory
- clk  in  1  single clock; also drives clk2 of the memory
- reset  in  1  synchronous, active-high
- cfg_start  in  1  one-cycle pulse; latches cfg_* and begins a run; ignored while busy=1
- cfg_base  in  ADDR_W  first word address; must be < DEPTH
- cfg_length  in  ADDR_W  words per pass; 0 is legal and means an empty run
- cfg_loop  in  1  1 = repeat the window until cfg_abort
- cfg_abort  in  1  pulse; terminates the run and discards buffered data
- busy  out  1  high from the cycle after cfg_start until the cycle after done
- done  out  1  one-cycle pulse at the end of a run
- mem_address  out  ADDR_W  to s2 address2
- mem_chipselect, mem_clken  out  1  both equal the issue strobe
- mem_write  out  1  constant 0
- mem_byteenable  out  8  constant 8'hFF
- mem_readdata  in  DATA_W  s2 readdata2; valid the cycle after issue
- out_data  out  DATA_W  stream data
- out_valid  out  1  stream valid
- out_last  out  1  last word of the current pass
- out_ready  in  1  stream ready

## Operation
- States:
  - IDLE: a cfg_start pulse moves to RUN, or to DONE if cfg_length=0.
  - RUN: issues reads. After the last issue of a pass, goes to DRAIN if cfg_loop=0; stays in RUN and reloads the pass with cfg_loop=1.
  - DRAIN: waits until the FIFO is empty and no read is in flight, then goes to DONE.
  - FLUSH: entered on cfg_abort; lasts 1 cycle and discards the in-flight word.
  - DONE: lasts 1 cycle with done=1, then goes to IDLE.
- Issue condition: state=RUN, pass words remaining > 0, and (fifo_count + inflight − pop) < 2. Here pop = out_valid & out_ready, and inflight is the registered issue strobe from the previous cycle.
- Address: starts at cfg_base and increments by 1 per issue. DEPTH−1 wraps to 0 (compare against DEPTH, not 2^ADDR_W). Each loop pass restarts at cfg_base.
- Every issued word is written into the FIFO the cycle after issue. Its out_last flag is set when it was the final issue of a pass.
- cfg_abort in RUN or DRAIN: go to FLUSH, clear the FIFO immediately, and drop out_valid in the next cycle. FLUSH then goes to DONE. cfg_abort in IDLE or DONE is ignored.
- cfg_start and cfg_abort together in IDLE: start wins, abort is ignored.
- Reset values: busy=0, done=0, out_valid=0, out_last=0, out_data=0, mem_chipselect=0, mem_clken=0, mem_address=0. The FIFO is empty and the state is IDLE. Reset mid-run abandons the run with no done pulse.

## Timing
- cfg_start at cycle 0, then:
  - first issue at cycle 1;
  - mem_readdata valid at cycle 2;
  - out_valid=1 at cycle 3.
- With out_ready held high there is one word per cycle and no bubbles.
- Non-loop run of N words with out_ready high: the last beat is at cycle N+2, done at cycle N+3, and busy falls at cycle N+4.
- out_data and out_valid are registered FIFO-head outputs. They stay stable while out_valid=1 and out_ready=0.
- Backpressure: the FIFO never exceeds 2 entries, and no word is lost or duplicated.

## Structure
- Shared package on_chip_mem_pkg: ADDR_W, DATA_W, DEPTH, and the state enum {IDLE, RUN, DRAIN, FLUSH, DONE}.
- Sub-module mem_rd_skid_fifo: 2-entry FIFO of {last, data}, with push, pop, clear, count[1:0] and head outputs.
- The top level holds the FSM, the address/remaining counters, the inflight register and the issue logic.

## Test plan
- Basic run: base=0, length=4, loop=0, ready=1 → mem_address 0,1,2,3 on cycles 1–4; beats on cycles 3–6 with out_last on cycle 6; done on cycle 7.
- Wrap: base=8958, length=4 → addresses 8958, 8959, 0, 1, and data matches the memory model.
- Backpressure: length=8, out_ready toggling 1,0,0,1,… → all 8 words delivered in order exactly once; FIFO count ≤2; data held stable while stalled.
- Loop then abort: base=100, length=3, loop=1 → sequence 100,101,102,100,… with out_last on every 102. Abort pulse mid-stream → out_valid=0 next cycle, done 2 cycles after abort, no beats afterwards.
- Empty run: length=0 → no mem_chipselect, done one cycle after start. A second cfg_start while busy=1 has no effect.
- Reset after 2 beats of a length=6 run → all outputs at reset values the next cycle, no done pulse. A fresh start then runs normally.
